alu_op_decoder: RTL and testbench

- Producer end of the ALU operation interface: decodes one RV64 instruction per handshake into a 4-bit ALU op plus operands `a` and `b`.
- Sits between register-file read and the combinational ALU, forming the ID/EX pipeline register.
- Uses a valid/ready handshake with a skid buffer so throughput is one instruction per cycle under backpressure.

---
 rtl/alu_dec_pkg.sv | 46 ++++
 rtl/alu_dec_comb.sv | 154 +++++++++++++++
 rtl/alu_op_decoder.sv | 137 +++++++++++++
 tb/tb_alu_op_decoder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dec_pkg.sv
// rtl/alu_dec_pkg.sv - shared ALU op codes, RISC-V opcodes and decoded-entry type
package alu_dec_pkg;

    localparam logic [3:0] ALU_XOR = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_NE  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        is_branch;
        logic        illegal;
    } dec_entry_t;

    localparam int DEC_ENTRY_W = $bits(dec_entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic logic [63:0] sext12(input logic [11:0] v);
        return {{52{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu_dec_comb.sv
// rtl/alu_dec_comb.sv - combinational RV64 instruction to ALU entry decoder
module alu_dec_comb
    import alu_dec_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [63:0] pc,
    input  logic [63:0] rs1_data,
    input  logic [63:0] rs2_data,
    output dec_entry_t  entry
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_u;
    logic [63:0] shamt_r;
    logic [63:0] shamt_i;

    logic        legal;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        br;

    assign opcode  = instr[6:0];
    assign funct3  = instr[14:12];
    assign funct7  = instr[31:25];
    assign imm_i   = sext12(instr[31:20]);
    assign imm_s   = sext12({instr[31:25], instr[11:7]});
    assign imm_u   = {{32{instr[31]}}, instr[31:12], 12'b0};
    assign shamt_r = {58'b0, rs2_data[5:0]};
    assign shamt_i = {58'b0, instr[25:20]};

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        br    = 1'b0;
        case (opcode)
            OPC_OP: begin
                a = rs1_data;
                b = rs2_data;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            legal = 1'b1;
                            op    = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            legal = 1'b1;
                            op    = ALU_SUB;
                        end
                    end
                    3'b001: begin
                        legal = (funct7 == F7_BASE);
                        op    = ALU_SLL;
                        b     = shamt_r;
                    end
                    3'b100: begin
                        legal = (funct7 == F7_BASE);
                        op    = ALU_XOR;
                    end
                    3'b101: begin
                        b = shamt_r;
                        if (funct7 == F7_BASE) begin
                            legal = 1'b1;
                            op    = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            legal = 1'b1;
                            op    = ALU_SRA;
                        end
                    end
                    3'b110: begin
                        legal = (funct7 == F7_BASE);
                        op    = ALU_OR;
                    end
                    3'b111: begin
                        legal = (funct7 == F7_BASE);
                        op    = ALU_AND;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                a = rs1_data;
                b = imm_i;
                case (funct3)
                    3'b000: begin legal = 1'b1; op = ALU_ADD; end
                    3'b100: begin legal = 1'b1; op = ALU_XOR; end
                    3'b110: begin legal = 1'b1; op = ALU_OR;  end
                    3'b111: begin legal = 1'b1; op = ALU_AND; end
                    3'b001: begin
                        legal = (instr[31:26] == 6'b000000);
                        op    = ALU_SLL;
                        b     = shamt_i;
                    end
                    3'b101: begin
                        b = shamt_i;
                        if (instr[31:26] == 6'b000000) begin
                            legal = 1'b1;
                            op    = ALU_SRL;
                        end else if (instr[31:26] == 6'b010000) begin
                            legal = 1'b1;
                            op    = ALU_SRA;
                        end
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal = 1'b1;
                a     = rs1_data;
                b     = imm_i;
            end
            OPC_STORE: begin
                legal = 1'b1;
                a     = rs1_data;
                b     = imm_s;
            end
            OPC_BRANCH: begin
                a  = rs1_data;
                b  = rs2_data;
                br = 1'b1;
                if (funct3 == 3'b000) begin
                    legal = 1'b1;
                    op    = ALU_EQ;
                end else if (funct3 == 3'b001) begin
                    legal = 1'b1;
                    op    = ALU_NE;
                end
            end
            OPC_LUI: begin
                legal = 1'b1;
                b     = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                a     = pc;
                b     = imm_u;
            end
            default: legal = 1'b0;
        endcase

        // Undecodable entries carry a fixed, harmless payload.
        entry.op        = legal ? op : ALU_ADD;
        entry.a         = legal ? a : '0;
        entry.b         = legal ? b : '0;
        entry.is_branch = legal & br;
        entry.illegal   = ~legal;
    end

endmodule

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - ID/EX stage with skid buffer; optional ALU_DEC_ILLEGAL_TRAP_EN
module alu_op_decoder
    import alu_dec_pkg::*;
#(
    parameter int XLEN = 64,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      op,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            is_branch,
    output logic            illegal
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    ,
    output logic            trap
`endif
);

    dec_entry_t  dec;
    dec_entry_t  out_q;
    dec_entry_t  skid_q;
    skid_state_t state;
    skid_state_t state_nx;

    logic accept;
    logic push;
    logic drain;
    logic room;
    logic load_out;
    logic out_from_skid;
    logic load_skid;

    alu_dec_comb u_comb (
        .instr    (instr),
        .pc       (pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .entry    (dec)
    );

    // Skid mode derives in_ready from state alone; single-register mode looks through to out_ready.
    assign room   = SKID ? (state != ST_FULL) : ((state == ST_EMPTY) || out_ready);
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic trap_q;

    assign in_ready = room && !trap_q;
    assign push     = accept && !dec.illegal;
    assign trap     = trap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else if (accept && dec.illegal) begin
            trap_q <= 1'b1;
        end
    end
`else
    assign in_ready = room;
    assign push     = accept;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        load_out      = 1'b0;
        out_from_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    load_out = 1'b1;
                    state_nx = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && drain) begin
                    load_out = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    state_nx  = ST_FULL;
                end else if (drain) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                    state_nx      = ST_ONE;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= out_from_skid ? skid_q : dec;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign out_valid = (state != ST_EMPTY);
    assign op        = out_q.op;
    assign a         = out_q.a;
    assign b         = out_q.b;
    assign is_branch = out_q.is_branch;
    assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// tb/tb_alu_op_decoder.sv - randomized scoreboard bench for alu_op_decoder
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;
    logic [63:0] rs1_data = '0;
    logic [63:0] rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_branch;
    logic        illegal;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    logic        trap;
`endif

    always #5 clk = ~clk;

    alu_op_decoder #(.XLEN(64), .SKID(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .is_branch (is_branch),
        .illegal   (illegal)
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        ,
        .trap      (trap)
`endif
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] seen_a[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          drains = 0;
    logic        trap_exp = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] sx(input longint v, input int bits);
        longint r = v;
        if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
        return 64'(r);
    endfunction

    // Reference decode from the instruction-set rules, using plain arithmetic.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pcv,
                                   input logic [63:0] r1, input logic [63:0] r2);
        exp_t e;
        int   opc = int'(ins[6:0]);
        int   f3  = int'(ins[14:12]);
        int   f7  = int'(ins[31:25]);
        int   top6 = int'(ins[31:26]);
        bit   ok  = 0;
        e.op = 4'd1; e.a = 0; e.b = 0; e.br = 0; e.ill = 0;
        case (opc)
            'h33: begin
                e.a = r1; e.b = r2;
                if (f7 == 0 && f3 != 2 && f3 != 3) begin
                    ok = 1;
                    e.op = (f3 == 0) ? 4'd1 : (f3 == 1) ? 4'd5 : (f3 == 4) ? 4'd0 :
                           (f3 == 5) ? 4'd6 : (f3 == 6) ? 4'd4 : 4'd3;
                end else if (f7 == 32 && (f3 == 0 || f3 == 5)) begin
                    ok = 1;
                    e.op = (f3 == 0) ? 4'd2 : 4'd7;
                end
                if (f3 == 1 || f3 == 5) e.b = r2 % 64;
            end
            'h13: begin
                e.a = r1; e.b = sx(longint'(ins[31:20]), 12);
                if (f3 == 0) begin ok = 1; e.op = 4'd1; end
                if (f3 == 4) begin ok = 1; e.op = 4'd0; end
                if (f3 == 6) begin ok = 1; e.op = 4'd4; end
                if (f3 == 7) begin ok = 1; e.op = 4'd3; end
                if (f3 == 1 || f3 == 5) e.b = 64'(ins[25:20]);
                if (f3 == 1 && top6 == 0) begin ok = 1; e.op = 4'd5; end
                if (f3 == 5 && top6 == 0) begin ok = 1; e.op = 4'd6; end
                if (f3 == 5 && top6 == 16) begin ok = 1; e.op = 4'd7; end
            end
            'h03: begin ok = 1; e.a = r1; e.b = sx(longint'(ins[31:20]), 12); end
            'h23: begin ok = 1; e.a = r1; e.b = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
            'h63: begin
                if (f3 < 2) begin ok = 1; e.op = 4'(8 + f3); e.a = r1; e.b = r2; e.br = 1; end
            end
            'h37: begin ok = 1; e.b = sx(longint'(ins[31:12]) * 4096, 32); end
            'h17: begin ok = 1; e.a = pcv; e.b = sx(longint'(ins[31:12]) * 4096, 32); end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.op = 4'd1; e.a = 0; e.b = 0; e.br = 0; e.ill = 1;
        end
        return e;
    endfunction

    function automatic logic [6:0] pick7();
        int s = int'($urandom % 3);
        return (s == 0) ? 7'd0 : (s == 1) ? 7'd32 : 7'($urandom);
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int          tries = 0;
        exp_t        e;
        do begin
            int s = int'($urandom % 9);
            w = $urandom;
            case (s)
                0: begin w[6:0] = 7'h33; w[31:25] = pick7(); end
                1: begin w[6:0] = 7'h13; w[31:26] = 6'(pick7() >> 1); end
                2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;
                4: w[6:0] = 7'h63;
                5: w[6:0] = 7'h37;
                6: w[6:0] = 7'h17;
                7: ;
                default: begin w[6:0] = 7'h33; w[31:25] = 7'd0; end
            endcase
            e = model(w, 0, 0, 0);
            tries++;
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        end while (e.ill && tries < 20);
        if (e.ill) w = 32'h002081B3;
`else
        end while (tries < 1);
`endif
        return w;
    endfunction

    // Scoreboard and compare process, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            trap_exp = 1'b0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
            chk("rst_trap", 64'(trap), 64'd0);
`endif
        end else begin
            chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(sb.size() < 2 && !trap_exp));
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
            chk("trap", 64'(trap), 64'(trap_exp));
`endif
            if (out_valid && sb.size() > 0) begin
                chk("op", 64'(op), 64'(sb[0].op));
                chk("a", a, sb[0].a);
                chk("b", b, sb[0].b);
                chk("is_branch", 64'(is_branch), 64'(sb[0].br));
                chk("illegal", 64'(illegal), 64'(sb[0].ill));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                seen_a.push_back(a);
                drains++;
                void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                e = model(instr, pc, rs1_data, rs2_data);
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
                if (e.ill) trap_exp = 1'b1;
                else sb.push_back(e);
`else
                sb.push_back(e);
`endif
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] pcv,
                        input logic [63:0] r1, input logic [63:0] r2);
        bit got = 0;
        in_valid = 1'b1; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1; break; end
        end
        if (!got) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    int k_acc;
    bit acc_now;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_op", 64'(op), 64'd0);
        chk("reset_a", a, 64'd0);
        chk("reset_b", b, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        send(32'h002081B3, 64'h1000, 64'd5, 64'd7);
        @(negedge clk);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_op", 64'(op), 64'h1);
        chk("add_a", a, 64'd5);
        chk("add_b", b, 64'd7);
        chk("add_ill", 64'(illegal), 64'd0);
        send(32'h402081B3, 64'h1004, 64'd5, 64'd7);
        @(negedge clk);
        chk("sub_op", 64'(op), 64'h2);
        send(32'hFFF00093, 64'h1008, 64'd3, 64'd0);
        @(negedge clk);
        chk("addi_op", 64'(op), 64'h1);
        chk("addi_b", b, 64'hFFFF_FFFF_FFFF_FFFF);
        send(32'h43F35293, 64'h100C, 64'h8000_0000_0000_0000, 64'd0);
        @(negedge clk);
        chk("srai_op", 64'(op), 64'h7);
        chk("srai_b", b, 64'd63);
        send(32'h00208063, 64'h1010, 64'd9, 64'd9);
        @(negedge clk);
        chk("beq_op", 64'(op), 64'h8);
        chk("beq_br", 64'(is_branch), 64'd1);
        chk("beq_a", a, 64'd9);
        chk("beq_b", b, 64'd9);
        @(posedge clk); #1;

        // Backpressure: two entries fit, release drains four back to back.
        out_ready = 1'b0;
        k_acc = 0;
        in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 64'd1; rs2_data = 64'd0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); acc_now = in_ready;
            @(posedge clk); #1;
            if (acc_now) begin k_acc++; rs1_data = 64'(k_acc + 1); end
        end
        chk("bp_accepted", 64'(k_acc), 64'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        seen_a.delete(); drains = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); acc_now = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc_now) begin
                k_acc++;
                if (k_acc == 4) in_valid = 1'b0;
                else rs1_data = 64'(k_acc + 1);
            end
        end
        in_valid = 1'b0;
        chk("bp_total_acc", 64'(k_acc), 64'd4);
        chk("bp_drains_4cyc", 64'(drains), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("bp_order", (i < seen_a.size()) ? seen_a[i] : 64'hDEAD, 64'(i + 1));

        // Asynchronous reset while FULL.
        out_ready = 1'b0;
        send(32'h002081B3, 64'h0, 64'd11, 64'd1);
        send(32'h002081B3, 64'h0, 64'd12, 64'd1);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_op", 64'(op), 64'd0);
        chk("arst_a", a, 64'd0);
        chk("arst_b", b, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h002081B3, 64'h0, 64'h55, 64'd1);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_a", a, 64'h55);
        @(negedge clk);
        chk("post_rst_alone", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Random traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            instr     = gen();
            pc        = {$urandom, $urandom};
            rs1_data  = {$urandom, $urandom};
            rs2_data  = {$urandom, $urandom};
            out_ready = ($urandom % 3) != 0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("final_drained", 64'(sb.size()), 64'd0);

        // Illegal (slt).
        send(32'h0020A1B3, 64'h2000, 64'd4, 64'd6);
        @(negedge clk);
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
        chk("trap_no_valid", 64'(out_valid), 64'd0);
        chk("trap_set", 64'(trap), 64'd1);
        chk("trap_in_ready", 64'(in_ready), 64'd0);
`else
        chk("slt_valid", 64'(out_valid), 64'd1);
        chk("slt_ill", 64'(illegal), 64'd1);
        chk("slt_op", 64'(op), 64'h1);
        chk("slt_a", a, 64'd0);
        chk("slt_b", b, 64'd0);
`endif
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
